sim_exit_monitor: RTL and testbench

//  Harness-side end-of-test monitor; produces the io_success/failure verdict the simulation driver polls each cycle.

---
 rtl/sim_exit_pkg.sv | 22 ++
 rtl/sim_exit_watchdog.sv | 33 +++
 rtl/sim_exit_monitor.sv | 109 ++++++++++
 tb/tb_sim_exit_monitor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sim_exit_pkg.sv
// Shared types for the simulation end-of-test monitor.
package sim_exit_pkg;

  // Width of the fail_reason output.
  localparam int REASON_W = 2;

  // Monitor FSM states. PASS and FAIL are terminal until reset.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_e;

  // Why the run ended in FAIL. NONE is also reported for PASS.
  typedef enum logic [REASON_W-1:0] {
    REASON_NONE      = 2'd0,
    REASON_EXIT_CODE = 2'd1,
    REASON_TIMEOUT   = 2'd2,
    REASON_WATCHDOG  = 2'd3
  } fail_reason_e;

endpackage

// File: rtl/sim_exit_watchdog.sv
// Idle watchdog for the end-of-test monitor. Counts RUN edges since the last
// accepted tohost word and flags expiry on the WDOG_CYCLES-th idle edge.
module sim_exit_watchdog #(
  parameter int unsigned WDOG_CYCLES = 32'd1000000,
  parameter int          WDOG_W      = 32
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(WDOG_CYCLES - 32'd1);

  logic [WDOG_W-1:0] idle_count_reg;

  // Idle counter: cleared by any accept, advances only while running, and
  // parks at LIMIT so it can never wrap back to a "fresh" value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idle_count_reg <= '0;
    end else if (kick) begin
      idle_count_reg <= '0;
    end else if (enable && (idle_count_reg != LIMIT)) begin
      idle_count_reg <= idle_count_reg + WDOG_W'(1);
    end
  end

  // Expiry is judged on the edge itself: an accept on that edge rescues it.
  assign expired = enable && !kick && (idle_count_reg == LIMIT);

endmodule

// File: rtl/sim_exit_monitor.sv
// Harness-side end-of-test monitor: accepts tohost words and latches a sticky
// PASS/FAIL verdict with exit code and reason.
// Optional idle watchdog enabled by defining SIM_EXIT_WATCHDOG_EN.
module sim_exit_monitor
  import sim_exit_pkg::*;
#(
  parameter int          DATA_W      = 64,
  parameter int          CNT_W       = 64,
  parameter int unsigned WDOG_CYCLES = 32'd1000000,
  parameter int          WDOG_W      = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                tohost_valid,
  output logic                tohost_ready,
  input  logic [DATA_W-1:0]   tohost_data,
  input  logic [CNT_W-1:0]    max_cycles,
  output logic                io_success,
  output logic                io_failure,
  output logic [DATA_W-2:0]   exit_code,
  output logic [REASON_W-1:0] fail_reason,
  output logic [CNT_W-1:0]    cycle_count
);

  state_e            state_reg, state_next;
  fail_reason_e      fail_reason_reg, fail_reason_next;
  logic [DATA_W-2:0] exit_code_reg, exit_code_next;
  logic [CNT_W-1:0]  cycle_count_reg;
  logic              ready_reg;
  logic              accept;
  logic              timeout_hit;
  logic              wdog_expired;

  assign accept      = tohost_valid && ready_reg;
  assign timeout_hit = (max_cycles != '0) && (cycle_count_reg >= max_cycles);

  // A watchdog limit that does not fit its counter is a configuration error.
  if ((WDOG_CYCLES == 32'd0) ||
      ((WDOG_W < 32) && (WDOG_CYCLES >= (32'd1 << WDOG_W)))) begin : g_bad_wdog_cfg
    $error("sim_exit_monitor: WDOG_CYCLES must lie in [1, 2**WDOG_W)");
  end

`ifdef SIM_EXIT_WATCHDOG_EN
  sim_exit_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES),
    .WDOG_W      (WDOG_W)
  ) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (state_reg == RUN),
    .kick    (accept),
    .expired (wdog_expired)
  );
`else
  assign wdog_expired = 1'b0;
`endif

  // Next-state and verdict latching. Exit write beats timeout beats watchdog;
  // terminal states hold everything regardless of further writes.
  always_comb begin
    state_next       = state_reg;
    exit_code_next   = exit_code_reg;
    fail_reason_next = fail_reason_reg;
    if (state_reg == RUN) begin
      if (accept && tohost_data[0]) begin
        exit_code_next = tohost_data[DATA_W-1:1];
        if (tohost_data[DATA_W-1:1] == '0) begin
          state_next = PASS;
        end else begin
          state_next       = FAIL;
          fail_reason_next = REASON_EXIT_CODE;
        end
      end else if (timeout_hit) begin
        state_next       = FAIL;
        fail_reason_next = REASON_TIMEOUT;
      end else if (wdog_expired) begin
        state_next       = FAIL;
        fail_reason_next = REASON_WATCHDOG;
      end
    end
  end

  // State, verdict payload, always-ready handshake and saturating run counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= RUN;
      exit_code_reg   <= '0;
      fail_reason_reg <= REASON_NONE;
      cycle_count_reg <= '0;
      ready_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      exit_code_reg   <= exit_code_next;
      fail_reason_reg <= fail_reason_next;
      ready_reg       <= 1'b1;
      if ((state_reg == RUN) && (cycle_count_reg != '1)) begin
        cycle_count_reg <= cycle_count_reg + CNT_W'(1);
      end
    end
  end

  assign tohost_ready = ready_reg;
  assign io_success   = (state_reg == PASS);
  assign io_failure   = (state_reg == FAIL);
  assign exit_code    = exit_code_reg;
  assign fail_reason  = fail_reason_reg;
  assign cycle_count  = cycle_count_reg;

endmodule

// File: tb/tb_sim_exit_monitor.sv
// Directed self-checking bench for sim_exit_monitor.
// Watchdog scenario runs when SIM_EXIT_WATCHDOG_EN is defined; otherwise the
// bench confirms a long idle stretch never produces a failure.
module tb_sim_exit_monitor;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 64;

  logic              clock;
  logic              reset_n;
  logic              tohost_valid;
  logic              tohost_ready;
  logic [DATA_W-1:0] tohost_data;
  logic [CNT_W-1:0]  max_cycles;
  logic              io_success;
  logic              io_failure;
  logic [DATA_W-2:0] exit_code;
  logic [1:0]        fail_reason;
  logic [CNT_W-1:0]  cycle_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  sim_exit_monitor #(
    .DATA_W      (DATA_W),
    .CNT_W       (CNT_W),
    .WDOG_CYCLES (32'd16),
    .WDOG_W      (8)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .tohost_valid (tohost_valid),
    .tohost_ready (tohost_ready),
    .tohost_data  (tohost_data),
    .max_cycles   (max_cycles),
    .io_success   (io_success),
    .io_failure   (io_failure),
    .exit_code    (exit_code),
    .fail_reason  (fail_reason),
    .cycle_count  (cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One tohost word presented for exactly one edge.
  task automatic write_word(input logic [DATA_W-1:0] w);
    $display("write tohost 0x%0h at cycle_count %0d", w, cycle_count);
    tohost_valid = 1'b1;
    tohost_data  = w;
    @(negedge clock);
    tohost_valid = 1'b0;
    tohost_data  = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".success"}, 64'(io_success), 64'd0);
    check({tag, ".failure"}, 64'(io_failure), 64'd0);
    check({tag, ".exit"},    64'(exit_code),  64'd0);
    check({tag, ".reason"},  64'(fail_reason), 64'd0);
    check({tag, ".count"},   cycle_count,     64'd0);
    check({tag, ".ready"},   64'(tohost_ready), 64'd0);
  endtask

  // Reset asserted for one cycle, released on a falling edge.
  task automatic do_reset(input logic [CNT_W-1:0] maxc);
    @(negedge clock);
    reset_n      = 1'b0;
    tohost_valid = 1'b0;
    tohost_data  = '0;
    max_cycles   = maxc;
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    tohost_valid = 1'b0;
    tohost_data  = '0;
    max_cycles   = '0;

    // 1: exit 0 at cycle_count 5 -> PASS, count frozen at 6
    do_reset('0);
    step(5);
    check("t1.count_before", cycle_count, 64'd5);
    check("t1.ready", 64'(tohost_ready), 64'd1);
    write_word(64'h1);
    check("t1.success", 64'(io_success), 64'd1);
    check("t1.failure", 64'(io_failure), 64'd0);
    check("t1.exit",    64'(exit_code),  64'd0);
    check("t1.reason",  64'(fail_reason), 64'd0);
    check("t1.count",   cycle_count,     64'd6);
    step(3);
    check("t1.count_frozen", cycle_count, 64'd6);
    check("t1.success_sticky", 64'(io_success), 64'd1);

    // 2: exit code 3 -> FAIL/EXIT_CODE; later write ignored
    do_reset('0);
    step(3);
    write_word(64'h7);
    check("t2.failure", 64'(io_failure), 64'd1);
    check("t2.success", 64'(io_success), 64'd0);
    check("t2.exit",    64'(exit_code),  64'd3);
    check("t2.reason",  64'(fail_reason), 64'd1);
    check("t2.count",   cycle_count,     64'd4);
    write_word(64'h1);
    step(2);
    check("t2.post_success", 64'(io_success), 64'd0);
    check("t2.post_failure", 64'(io_failure), 64'd1);
    check("t2.post_exit",    64'(exit_code),  64'd3);
    check("t2.post_reason",  64'(fail_reason), 64'd1);
    check("t2.post_count",   cycle_count,     64'd4);
    check("t2.post_ready",   64'(tohost_ready), 64'd1);

    // 3: max_cycles 10, idle -> TIMEOUT with count 11
    do_reset(64'd10);
    step(10);
    check("t3.failure_early", 64'(io_failure), 64'd0);
    check("t3.count_early",   cycle_count,     64'd10);
    step(1);
    check("t3.failure", 64'(io_failure), 64'd1);
    check("t3.reason",  64'(fail_reason), 64'd2);
    check("t3.count",   cycle_count,     64'd11);
    check("t3.exit",    64'(exit_code),  64'd0);
    step(3);
    check("t3.success", 64'(io_success), 64'd0);
    check("t3.count_frozen", cycle_count, 64'd11);

    // 4: exit on the timeout edge -> PASS wins
    do_reset(64'd10);
    step(10);
    write_word(64'h1);
    check("t4.success", 64'(io_success), 64'd1);
    check("t4.failure", 64'(io_failure), 64'd0);
    check("t4.reason",  64'(fail_reason), 64'd0);
    check("t4.count",   cycle_count,     64'd11);

`ifdef SIM_EXIT_WATCHDOG_EN
    // 5: heartbeats every 10 edges keep it alive; then expiry 16 edges later
    do_reset('0);
    for (int i = 0; i < 10; i++) begin
      step(9);
      write_word(64'h2);
    end
    check("t5.alive_failure", 64'(io_failure), 64'd0);
    check("t5.alive_count",   cycle_count,     64'd100);
    step(15);
    check("t5.edge15_failure", 64'(io_failure), 64'd0);
    step(1);
    check("t5.failure", 64'(io_failure), 64'd1);
    check("t5.reason",  64'(fail_reason), 64'd3);
    check("t5.count",   cycle_count,     64'd116);
    check("t5.exit",    64'(exit_code),  64'd0);
`else
    // 5: no watchdog built -> long idle stretch after a heartbeat stays in RUN
    do_reset('0);
    step(3);
    write_word(64'h2);
    step(40);
    check("t5.failure", 64'(io_failure), 64'd0);
    check("t5.success", 64'(io_success), 64'd0);
    check("t5.reason",  64'(fail_reason), 64'd0);
    check("t5.count",   cycle_count,     64'd44);
`endif

    // 6: async reset while in FAIL clears everything before any edge
    do_reset('0);
    step(2);
    write_word(64'h5);
    check("t6.failure", 64'(io_failure), 64'd1);
    check("t6.exit",    64'(exit_code),  64'd2);
    check("t6.reason",  64'(fail_reason), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("t6.async");
    @(negedge clock);
    reset_n = 1'b1;
    step(2);
    check("t6.restart_count", cycle_count, 64'd2);
    check("t6.restart_ready", 64'(tohost_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
